// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped read-only instruction cache with combinational hit path
// Misses stall the requester while the line is filled one word per bus ack, word 0 first.
module icache_responder #(
    parameter int LINES     = 16,
    parameter int LINEWORDS = 4
) (
    input  logic        clk,
    input  logic        Nrst,
    input  logic [31:0] rd_addr,
    input  logic        rd_req,
    output logic        rd_wait,
    output logic [31:0] rd_data,
    input  logic        flush,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] miss_count
);

    localparam int WB    = $clog2(LINEWORDS);
    localparam int OFFB  = WB + 2;
    localparam int IDXB  = $clog2(LINES);
    localparam int TAGB  = 32 - OFFB - IDXB;
    localparam int LINEB = 32 - OFFB;
    localparam logic [WB-1:0] LAST_WORD = WB'(LINEWORDS - 1);

    typedef enum logic {IDLE, FILL} state_t;
    state_t state, state_next;

    logic [31:0]     data_mem [LINES*LINEWORDS];
    logic [TAGB-1:0] tag_mem  [LINES];
    logic [LINES-1:0] valid;

    logic [LINEB-1:0] fill_line;
    logic [WB-1:0]    cnt;
    logic [WB-1:0]    cnt_inc;
    logic             flush_pend;
    logic             start_fill, fill_ack, fill_last, hit;

    logic [IDXB-1:0] rd_idx;
    logic [WB-1:0]   rd_word;
    logic [TAGB-1:0] rd_tag;
    logic [IDXB-1:0] fill_idx;
    logic [TAGB-1:0] fill_tag;
    logic            unused_addr_bits;

    assign rd_idx   = rd_addr[OFFB +: IDXB];
    assign rd_word  = rd_addr[2 +: WB];
    assign rd_tag   = rd_addr[OFFB+IDXB +: TAGB];
    assign fill_idx = fill_line[IDXB-1:0];
    assign fill_tag = fill_line[LINEB-1:IDXB];
    assign cnt_inc  = cnt + WB'(1);
    assign unused_addr_bits = ^rd_addr[1:0];

    assign hit     = (state == IDLE) && valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_data = data_mem[{rd_idx, rd_word}];
    assign rd_wait = !Nrst || (state != IDLE) || (rd_req && !hit);

    always_ff @(posedge clk) begin
        if (!Nrst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_fill = 1'b0;
        fill_ack   = 1'b0;
        fill_last  = 1'b0;
        case (state)
            IDLE: begin
                // a flush cycle still answers hits from the old valid bits but never starts a fill
                if (rd_req && !hit && !flush) begin
                    start_fill = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (bus_ack) begin
                    fill_ack = 1'b1;
                    if (cnt == LAST_WORD) begin
                        fill_last  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Nrst) begin
            valid      <= '0;
            bus_req    <= 1'b0;
            bus_addr   <= '0;
            cnt        <= '0;
            miss_count <= '0;
            flush_pend <= 1'b0;
            fill_line  <= '0;
        end else begin
            if (start_fill) begin
                fill_line  <= rd_addr[31:OFFB];
                cnt        <= '0;
                bus_req    <= 1'b1;
                bus_addr   <= {rd_addr[31:OFFB], {WB{1'b0}}, 2'b00};
                miss_count <= miss_count + 32'd1;
            end
            if (fill_ack) begin
                cnt      <= cnt_inc;
                bus_addr <= {fill_line, cnt_inc, 2'b00};
                if (fill_last) bus_req <= 1'b0;
            end
            // flush beats a completing fill, and a flush seen mid-fill keeps that line invalid
            if (flush)
                valid <= '0;
            else if (fill_last && !flush_pend)
                valid[fill_idx] <= 1'b1;
            if (state_next == IDLE)
                flush_pend <= 1'b0;
            else if (flush && state == FILL)
                flush_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (Nrst && fill_ack) data_mem[{fill_idx, cnt}] <= bus_rdata;
        if (Nrst && fill_last) tag_mem[fill_idx] <= fill_tag;
    end

endmodule

// File: tb/tb_icache_responder.sv
// tb/tb_icache_responder.sv - randomized self-checking bench for icache_responder
module tb_icache_responder;

    localparam int LINES     = 16;
    localparam int LINEWORDS = 4;
    localparam int unsigned LBYTES = LINEWORDS * 4;

    logic        clk = 1'b0;
    logic        Nrst = 1'b0;
    logic [31:0] rd_addr = '0;
    logic        rd_req = 1'b0;
    logic        rd_wait;
    logic [31:0] rd_data;
    logic        flush = 1'b0;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic [31:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    int period    = 1;
    int wcnt      = 0;
    bit force_ack = 1'b0;
    logic [31:0] ack_log[$];

    bit          m_valid[LINES];
    int unsigned m_tag[LINES];
    int unsigned m_mc;

    icache_responder #(.LINES(LINES), .LINEWORDS(LINEWORDS)) dut (
        .clk(clk), .Nrst(Nrst), .rd_addr(rd_addr), .rd_req(rd_req), .rd_wait(rd_wait),
        .rd_data(rd_data), .flush(flush), .bus_req(bus_req), .bus_addr(bus_addr),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // backing memory: acks every period-th cycle while a request is pending
    always @(negedge clk) begin
        bus_rdata = memf(bus_addr);
        if (force_ack) begin
            bus_ack = 1'b1;
        end else if (bus_req) begin
            if (wcnt >= period - 1) begin
                bus_ack = 1'b1;
                wcnt = 0;
            end else begin
                bus_ack = 1'b0;
                wcnt++;
            end
        end else begin
            bus_ack = 1'b0;
            wcnt = 0;
        end
    end

    always @(posedge clk)
        if (Nrst && bus_req && bus_ack) ack_log.push_back(bus_addr);

    function automatic void model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / LBYTES) % LINES);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return a / (LBYTES * LINES);
    endfunction

    function automatic void model_fill(input logic [31:0] a);
        m_valid[idx_of(a)] = 1'b1;
        m_tag[idx_of(a)]   = tag_of(a);
        m_mc++;
    endfunction

    task automatic wait_serve(inout int cyc);
        while (rd_wait && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        int cyc, q0, exp_cyc;
        bit exp_hit;
        logic [31:0] base;
        exp_hit = m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
        exp_cyc = exp_hit ? 0 : LINEWORDS * period + 1;
        base = a - (a % LBYTES);
        q0 = ack_log.size();
        @(negedge clk);
        rd_addr = a;
        rd_req  = 1'b1;
        #1;
        cyc = 0;
        wait_serve(cyc);
        n_checks++;
        if (rd_wait !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_timeout addr=%h rd_wait=%b required 0", a, rd_wait);
            return;
        end
        n_checks++;
        if (cyc != exp_cyc) begin
            n_fail++;
            $display("FAIL fetch_latency addr=%h got %0d cycles required %0d", a, cyc, exp_cyc);
        end
        n_checks++;
        if (rd_data !== memf(a)) begin
            n_fail++;
            $display("FAIL fetch_data addr=%h got %h required %h", a, rd_data, memf(a));
        end
        if (!exp_hit) begin
            model_fill(a);
            n_checks++;
            if (ack_log.size() != q0 + LINEWORDS) begin
                n_fail++;
                $display("FAIL fill_words addr=%h got %0d required %0d", a, ack_log.size() - q0, LINEWORDS);
            end else begin
                for (int k = 0; k < LINEWORDS; k++) begin
                    n_checks++;
                    if (ack_log[q0+k] !== base + 32'(4*k)) begin
                        n_fail++;
                        $display("FAIL fill_order word %0d got %h required %h", k, ack_log[q0+k], base + 32'(4*k));
                    end
                end
            end
        end
        n_checks++;
        if (miss_count !== m_mc) begin
            n_fail++;
            $display("FAIL miss_count addr=%h got %0d required %0d", a, miss_count, m_mc);
        end
    endtask

    task automatic test_reset();
        Nrst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (rd_wait !== 1'b1) begin n_fail++; $display("FAIL reset_rd_wait got %b required 1", rd_wait); end
        n_checks++;
        if (bus_req !== 1'b0 || bus_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_bus got req=%b addr=%h required 0/0", bus_req, bus_addr);
        end
        n_checks++;
        if (miss_count !== 32'h0) begin n_fail++; $display("FAIL reset_miss_count got %0d required 0", miss_count); end
        Nrst = 1'b1;
        #1;
        n_checks++;
        if (rd_wait !== 1'b0) begin n_fail++; $display("FAIL idle_rd_wait got %b required 0", rd_wait); end
        model_clear();
        m_mc = 0;
    endtask

    task automatic test_cold_miss();
        period = 1;
        fetch(32'h100);
        n_checks++;
        if (miss_count !== 32'd1) begin n_fail++; $display("FAIL cold_miss_count got %0d required 1", miss_count); end
    endtask

    task automatic test_hits();
        fetch(32'h104);
        fetch(32'h108);
        fetch(32'h10C);
        n_checks++;
        if (bus_req !== 1'b0) begin n_fail++; $display("FAIL hit_bus_req got %b required 0", bus_req); end
    endtask

    task automatic test_conflict();
        fetch(32'h200);
        fetch(32'h100);
        n_checks++;
        if (miss_count !== 32'd3) begin n_fail++; $display("FAIL conflict_miss_count got %0d required 3", miss_count); end
    endtask

    task automatic test_addr_change();
        int cyc;
        @(negedge clk);
        rd_req = 1'b0;
        flush  = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
        period = 3;
        ack_log.delete();
        rd_addr = 32'h100;
        rd_req  = 1'b1;
        cyc = 0;
        while (ack_log.size() < 1 && cyc < 100) begin @(negedge clk); cyc++; end
        rd_addr = 32'h40;
        #1;
        wait_serve(cyc);
        n_checks++;
        if (rd_wait !== 1'b0 || rd_data !== memf(32'h40)) begin
            n_fail++; $display("FAIL jump_serve got wait=%b data=%h required 0/%h", rd_wait, rd_data, memf(32'h40));
        end
        n_checks++;
        if (ack_log.size() != 2 * LINEWORDS) begin
            n_fail++; $display("FAIL jump_words got %0d required %0d", ack_log.size(), 2 * LINEWORDS);
        end else begin
            for (int k = 0; k < LINEWORDS; k++) begin
                n_checks++;
                if (ack_log[k] !== 32'h100 + 32'(4*k) || ack_log[LINEWORDS+k] !== 32'h40 + 32'(4*k)) begin
                    n_fail++;
                    $display("FAIL jump_order word %0d got %h/%h required %h/%h", k, ack_log[k],
                             ack_log[LINEWORDS+k], 32'h100 + 32'(4*k), 32'h40 + 32'(4*k));
                end
            end
        end
        model_fill(32'h100);
        model_fill(32'h40);
        n_checks++;
        if (miss_count !== m_mc) begin n_fail++; $display("FAIL jump_miss_count got %0d required %0d", miss_count, m_mc); end
        fetch(32'h100);
    endtask

    task automatic test_flush();
        int cyc;
        period = 1;
        fetch(32'h104);
        @(negedge clk);
        flush = 1'b1;
        #1;
        n_checks++;
        if (rd_wait !== 1'b0 || rd_data !== memf(32'h104)) begin
            n_fail++; $display("FAIL flush_same_cycle got wait=%b data=%h required 0/%h", rd_wait, rd_data, memf(32'h104));
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_checks++;
        if (rd_wait !== 1'b1 || miss_count !== m_mc) begin
            n_fail++; $display("FAIL flush_idle got wait=%b mc=%0d required 1/%0d", rd_wait, miss_count, m_mc);
        end
        rd_req = 1'b0;
        model_clear();
        // flush coinciding with the second ack of a fill
        ack_log.delete();
        @(negedge clk);
        rd_addr = 32'h300;
        rd_req  = 1'b1;
        cyc = 0;
        while (ack_log.size() < 1 && cyc < 100) begin @(negedge clk); cyc++; end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        wait_serve(cyc);
        model_fill(32'h300);
        m_mc++;
        n_checks++;
        if (rd_wait !== 1'b0 || rd_data !== memf(32'h300)) begin
            n_fail++; $display("FAIL flush_fill_serve got wait=%b data=%h required 0/%h", rd_wait, rd_data, memf(32'h300));
        end
        n_checks++;
        if (ack_log.size() != 2 * LINEWORDS || miss_count !== m_mc) begin
            n_fail++; $display("FAIL flush_fill_refetch got words=%0d mc=%0d required %0d/%0d",
                               ack_log.size(), miss_count, 2 * LINEWORDS, m_mc);
        end
    endtask

    task automatic test_reset_mid_fill();
        int cyc;
        period = 1;
        ack_log.delete();
        @(negedge clk);
        rd_addr = 32'h500;
        rd_req  = 1'b1;
        cyc = 0;
        while (ack_log.size() < 2 && cyc < 100) begin @(negedge clk); cyc++; end
        Nrst      = 1'b0;
        rd_req    = 1'b0;
        force_ack = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_fill_bus_req got %b required 0", bus_req); end
        Nrst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (bus_req !== 1'b0 || miss_count !== 32'd0 || ack_log.size() != 2) begin
            n_fail++; $display("FAIL stray_ack got req=%b mc=%0d words=%0d required 0/0/2", bus_req, miss_count, ack_log.size());
        end
        force_ack = 1'b0;
        model_clear();
        m_mc = 0;
        fetch(32'h500);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                rd_req = 1'b0;
                flush  = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                model_clear();
            end else begin
                period = int'($urandom_range(1, 3));
                a = {22'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00};
                fetch(a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hits();
        test_conflict();
        test_addr_change();
        test_flush();
        test_reset_mid_fill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
